// File: rtl/counter_sequencer.sv
// Programmable up/down/bounce count sequencer with command handshake,
// pass counting, endpoint dwell, abort and error reporting.
module counter_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PASS_W  = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [WIDTH-1:0]   cmd_lo,
  input  logic [WIDTH-1:0]   cmd_hi,
  input  logic [PASS_W-1:0]  cmd_passes,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DWELL = 2'b10
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  state_t             state, state_n;
  logic [1:0]         mode_q, mode_n;
  logic [WIDTH-1:0]   lo_q, lo_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [PASS_W-1:0]  passes_q, passes_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [PASS_W-1:0]  pass_cnt, pass_cnt_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [WIDTH-1:0]   count_n;
  logic               dir_n;
  logic               done_n;
  logic               err_n;

  logic [WIDTH-1:0]   endpoint_c;
  logic [WIDTH-1:0]   step_count_c;
  logic [WIDTH-1:0]   rs_count_c;
  logic               rs_dir_c;
  logic               last_pass_c;
  logic               illegal_c;

  // Endpoint, single step and pass-completion decode from current registers
  always_comb begin
    endpoint_c   = dir ? lo_q : hi_q;
    step_count_c = dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
    last_pass_c  = (passes_q != PASS_W'(0)) &&
                   ((pass_cnt + PASS_W'(1)) == passes_q);
    illegal_c    = (cmd_lo > cmd_hi) || (cmd_mode == MODE_RSVD);
  end

  // Restart action taken when a non-final pass completes (after any dwell)
  always_comb begin
    rs_count_c = count;
    rs_dir_c   = dir;
    case (mode_q)
      MODE_UP:   rs_count_c = lo_q;
      MODE_DOWN: rs_count_c = hi_q;
      default: begin
        rs_dir_c = ~dir;
        if (lo_q != hi_q)
          rs_count_c = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    mode_n      = mode_q;
    lo_n        = lo_q;
    hi_n        = hi_q;
    passes_n    = passes_q;
    dwell_n     = dwell_q;
    pass_cnt_n  = pass_cnt;
    dwell_cnt_n = dwell_cnt;
    count_n     = count;
    dir_n       = dir;
    done_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (illegal_c) begin
            err_n = 1'b1;
          end else begin
            mode_n     = cmd_mode;
            lo_n       = cmd_lo;
            hi_n       = cmd_hi;
            passes_n   = cmd_passes;
            dwell_n    = cmd_dwell;
            pass_cnt_n = PASS_W'(0);
            state_n    = RUN;
            if (cmd_mode == MODE_DOWN) begin
              count_n = cmd_hi;
              dir_n   = 1'b1;
            end else begin
              count_n = cmd_lo;
              dir_n   = 1'b0;
            end
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (count != endpoint_c) begin
          count_n = step_count_c;
        end else if (last_pass_c) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          pass_cnt_n = pass_cnt + PASS_W'(1);
          if (dwell_q != DWELL_W'(0)) begin
            state_n     = DWELL;
            dwell_cnt_n = dwell_q;
          end else begin
            count_n = rs_count_c;
            dir_n   = rs_dir_c;
          end
        end
      end

      DWELL: begin
        if (abort) begin
          state_n = IDLE;
        end else if (dwell_cnt == DWELL_W'(1)) begin
          state_n = RUN;
          count_n = rs_count_c;
          dir_n   = rs_dir_c;
        end else begin
          dwell_cnt_n = dwell_cnt - DWELL_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers; busy/cmd_ready decode the next state so they
  // line up with the state they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= MODE_UP;
      lo_q      <= '0;
      hi_q      <= '0;
      passes_q  <= '0;
      dwell_q   <= '0;
      pass_cnt  <= '0;
      dwell_cnt <= '0;
      count     <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      lo_q      <= lo_n;
      hi_q      <= hi_n;
      passes_q  <= passes_n;
      dwell_q   <= dwell_n;
      pass_cnt  <= pass_cnt_n;
      dwell_cnt <= dwell_cnt_n;
      count     <= count_n;
      dir       <= dir_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      err       <= err_n;
      cmd_ready <= (state_n == IDLE);
    end
  end

endmodule
